// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared opcodes, FSM states and immediate helpers for npc_mc
package npc_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        WB    = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        IMM_I    = 2'd0,
        IMM_U    = 2'd1,
        IMM_J    = 2'd2,
        IMM_NONE = 2'd3
    } imm_fmt_t;

    // 32-bit sign-extended immediate; callers widen to XLEN.
    function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_fmt_t fmt);
        case (fmt)
            IMM_I:   imm_gen = {{20{ir[31]}}, ir[31:20]};
            IMM_U:   imm_gen = {ir[31:12], 12'b0};
            IMM_J:   imm_gen = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_gen = 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/npc_mc_if.sv
// rtl/npc_mc_if.sv - instruction fetch, commit trace and halt status bundle
interface npc_mc_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_rdata;
    logic [XLEN-1:0] pc;
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic [4:0]      commit_rd;
    logic [XLEN-1:0] commit_data;
    logic            halt;
    logic            trap;

    modport master (
        output imem_req, imem_addr, pc,
        output commit_valid, commit_pc, commit_rd, commit_data,
        output halt, trap,
        input  imem_valid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, pc,
        input  commit_valid, commit_pc, commit_rd, commit_data,
        input  halt, trap,
        output imem_valid, imem_rdata
    );
endinterface

// File: rtl/npc_regfile.sv
// rtl/npc_regfile.sv - x0-hardwired register file, two async reads, one sync write
module npc_regfile #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_we,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_rd_data
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] r_regs [NREG];

    // Out-of-range indices for RV32E are trapped in decode, so only the low bits address.
    assign o_rs1_data = (i_rs1 == 5'd0) ? '0 : r_regs[i_rs1[AW-1:0]];
    assign o_rs2_data = (i_rs2 == 5'd0) ? '0 : r_regs[i_rs2[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_rd != 5'd0)) begin
            r_regs[i_rd[AW-1:0]] <= i_rd_data;
        end
    end

endmodule

// File: rtl/npc_mc.sv
// rtl/npc_mc.sv - multi-cycle RV32I/E subset core (FETCH/EXEC/WB/HALT)
// Optional: NPC_EBREAK_HALT_EN makes EBREAK halt the core instead of retiring as a NOP.
import npc_pkg::*;

module npc_mc #(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic      clk,
    input  logic      rst,
    npc_mc_if.master  bus
);
    localparam bit RV32E = (NREG <= 16);

    state_t          r_state;
    state_t          w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_next_pc;
    logic [31:0]     r_ir;
    logic            r_halt;
    logic            r_trap;
    logic            r_cv;
    logic [XLEN-1:0] r_cpc;
    logic [4:0]      r_crd;
    logic [XLEN-1:0] r_cdata;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [2:0]      w_f3;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    imm_fmt_t        w_fmt;
    logic            w_legal;
    logic            w_use_rd;
    logic            w_use_rs1;
    logic            w_use_rs2;
    logic            w_is_jump;
    logic            w_is_ebreak;
    logic            w_idx_bad;
    logic            w_misaligned;
    logic            w_fault;
    logic            w_ebreak_halt;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_link;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_result;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    npc_regfile #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_we       (r_state == WB),
        .i_rd       (r_crd),
        .i_rd_data  (r_cdata)
    );

    always_comb begin
        w_fmt       = IMM_NONE;
        w_legal     = 1'b0;
        w_use_rd    = 1'b0;
        w_use_rs1   = 1'b0;
        w_use_rs2   = 1'b0;
        w_is_jump   = 1'b0;
        w_is_ebreak = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                w_legal  = 1'b1;
                w_use_rd = 1'b1;
                w_fmt    = IMM_U;
            end
            OP_JAL: begin
                w_legal   = 1'b1;
                w_use_rd  = 1'b1;
                w_is_jump = 1'b1;
                w_fmt     = IMM_J;
            end
            OP_JALR: begin
                w_legal   = (w_f3 == F3_ADD);
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_is_jump = 1'b1;
                w_fmt     = IMM_I;
            end
            OP_IMM: begin
                w_legal   = (w_f3 == F3_ADD);
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_fmt     = IMM_I;
            end
            OP_REG: begin
                w_legal   = (w_f3 == F3_ADD) && ((w_f7 == F7_ADD) || (w_f7 == F7_SUB));
                w_use_rd  = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OP_SYSTEM: begin
                w_is_ebreak = (r_ir == INSN_EBREAK);
                w_legal     = w_is_ebreak;
            end
            default: ;
        endcase
    end

    assign w_idx_bad = RV32E && ((w_use_rd  && w_rd[4])  ||
                                 (w_use_rs1 && w_rs1[4]) ||
                                 (w_use_rs2 && w_rs2[4]));

    assign w_imm  = XLEN'($signed(imm_gen(r_ir, w_fmt)));
    assign w_link = r_pc + XLEN'(4);

    // JALR clears bit 0 of the target; bit 1 left set means a misaligned fetch.
    assign w_target = (w_opcode == OP_JALR)
                    ? ((w_rs1_data + w_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                    : (r_pc + w_imm);
    assign w_next_pc    = w_is_jump ? w_target : w_link;
    assign w_misaligned = w_is_jump && w_target[1];
    assign w_fault      = !w_legal || w_idx_bad || w_misaligned;

`ifdef NPC_EBREAK_HALT_EN
    assign w_ebreak_halt = w_is_ebreak;
`else
    assign w_ebreak_halt = 1'b0;
`endif

    always_comb begin
        w_result = '0;
        case (w_opcode)
            OP_LUI:           w_result = w_imm;
            OP_AUIPC:         w_result = r_pc + w_imm;
            OP_JAL, OP_JALR:  w_result = w_link;
            OP_IMM:           w_result = w_rs1_data + w_imm;
            OP_REG:           w_result = w_f7[5] ? (w_rs1_data - w_rs2_data)
                                                 : (w_rs1_data + w_rs2_data);
            default:          w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH:   if (bus.imem_valid) w_next_state = EXEC;
            EXEC:    w_next_state = (w_fault || w_ebreak_halt) ? HALT : WB;
            WB:      w_next_state = FETCH;
            HALT:    w_next_state = HALT;
            default: w_next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_next_pc <= RESET_PC;
            r_ir      <= '0;
            r_halt    <= 1'b0;
            r_trap    <= 1'b0;
            r_cv      <= 1'b0;
            r_cpc     <= '0;
            r_crd     <= '0;
            r_cdata   <= '0;
        end else begin
            r_cv <= 1'b0;
            case (r_state)
                FETCH: begin
                    if (bus.imem_valid) r_ir <= bus.imem_rdata;
                end
                EXEC: begin
                    if (w_fault) begin
                        r_halt <= 1'b1;
                        r_trap <= 1'b1;
                    end else if (w_ebreak_halt) begin
                        r_halt <= 1'b1;
                    end else begin
                        // Commit fields double as the WB write port into the regfile.
                        r_cv      <= 1'b1;
                        r_cpc     <= r_pc;
                        r_crd     <= w_use_rd ? w_rd : 5'd0;
                        r_cdata   <= w_result;
                        r_next_pc <= w_next_pc;
                    end
                end
                WB: begin
                    r_pc <= r_next_pc;
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req     = (r_state == FETCH);
    assign bus.imem_addr    = r_pc;
    assign bus.pc           = r_pc;
    assign bus.commit_valid = r_cv;
    assign bus.commit_pc    = r_cpc;
    assign bus.commit_rd    = r_crd;
    assign bus.commit_data  = r_cdata;
    assign bus.halt         = r_halt;
    assign bus.trap         = r_trap;

endmodule

// File: tb/tb_npc_mc.sv
// tb/tb_npc_mc.sv - randomized ISA-model bench for npc_mc plus directed pins
module tb_npc_mc;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npc_mc_if #(.XLEN(32)) bus   ();
    npc_mc_if #(.XLEN(32)) bus_e ();

    npc_mc #(.XLEN(32), .NREG(32), .RESET_PC(RST_PC)) u_dut   (.clk(clk), .rst(rst), .bus(bus));
    npc_mc #(.XLEN(32), .NREG(16), .RESET_PC(RST_PC)) u_dut_e (.clk(clk), .rst(rst), .bus(bus_e));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cyc0     = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    bit          m_halted;

    bit          chk_en = 1'b0;
    bit          e_req, e_cv, e_halt, e_trap;
    logic [31:0] e_pc, e_cpc, e_crd, e_cdata;
    logic [31:0] lc_pc, lc_rd, lc_data;
    int          lc_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("imem_req", 32'(bus.imem_req), 32'(e_req));
            if (e_req) check("imem_addr", bus.imem_addr, e_pc);
            check("pc", bus.pc, e_pc);
            check("commit_valid", 32'(bus.commit_valid), 32'(e_cv));
            if (e_cv && bus.commit_valid) begin
                check("commit_pc", bus.commit_pc, e_cpc);
                check("commit_rd", 32'(bus.commit_rd), e_crd);
                if (e_crd != 0) check("commit_data", bus.commit_data, e_cdata);
                lc_pc   = bus.commit_pc;
                lc_rd   = 32'(bus.commit_rd);
                lc_data = bus.commit_data;
                lc_cyc  = cyc;
            end
            check("halt", 32'(bus.halt), 32'(e_halt));
            check("trap", 32'(bus.trap), 32'(e_trap));
        end
    end

    // Architectural effect of one instruction word at m_pc.
    task automatic isa_step(input logic [31:0] w, output bit c, output bit h, output bit t,
                            output logic [4:0] rd, output logic [31:0] val, output logic [31:0] np);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a, b, immi, immu, immj;
        op   = w[6:0];
        f3   = w[14:12];
        rd   = w[11:7];
        a    = m_regs[w[19:15]];
        b    = m_regs[w[24:20]];
        immi = {{20{w[31]}}, w[31:20]};
        immu = {w[31:12], 12'b0};
        immj = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        c = 1'b1; h = 1'b0; t = 1'b0; val = 32'b0; np = m_pc + 32'd4;
        if (op == 7'h37) val = immu;
        else if (op == 7'h17) val = m_pc + immu;
        else if (op == 7'h6F) begin val = m_pc + 32'd4; np = m_pc + immj; end
        else if (op == 7'h67 && f3 == 3'd0) begin val = m_pc + 32'd4; np = (a + immi) & 32'hFFFF_FFFE; end
        else if (op == 7'h13 && f3 == 3'd0) val = a + immi;
        else if (op == 7'h33 && f3 == 3'd0 && w[31:25] == 7'h00) val = a + b;
        else if (op == 7'h33 && f3 == 3'd0 && w[31:25] == 7'h20) val = a - b;
        else if (w == 32'h0010_0073) begin
            rd = 5'd0;
`ifdef NPC_EBREAK_HALT_EN
            c = 1'b0; h = 1'b1;
`endif
        end else begin
            c = 1'b0; h = 1'b1; t = 1'b1;
        end
        if (c && np[1]) begin c = 1'b0; h = 1'b1; t = 1'b1; end
    endtask

    task automatic set_fetch();
        e_req = !m_halted;
        e_pc  = m_pc;
        e_cv  = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst = 1'b1;
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'h00A0_0093;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pc", bus.pc, RST_PC);
        check("rst_halt", 32'(bus.halt), 32'd0);
        check("rst_trap", 32'(bus.trap), 32'd0);
        check("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
        check("rst_commit_pc", bus.commit_pc, 32'd0);
        check("rst_commit_rd", 32'(bus.commit_rd), 32'd0);
        check("rst_commit_data", bus.commit_data, 32'd0);
        rst = 1'b0;
        bus.imem_valid = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc = RST_PC;
        m_halted = 1'b0;
        e_halt = 1'b0;
        e_trap = 1'b0;
        set_fetch();
        cyc0 = cyc;
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.imem_valid = m_halted ? 1'($urandom) : 1'b0;
            bus.imem_rdata = $urandom;
            set_fetch();
            @(posedge clk); #1;
        end
        bus.imem_valid = 1'b0;
    endtask

    task automatic run_instr(input logic [31:0] w, input int waits);
        bit c, h, t;
        logic [4:0]  rd;
        logic [31:0] v, np;
        for (int i = 0; i < waits; i++) begin
            bus.imem_valid = 1'b0;
            bus.imem_rdata = $urandom;
            set_fetch();
            @(posedge clk); #1;
        end
        bus.imem_valid = 1'b1;
        bus.imem_rdata = w;
        set_fetch();
        @(posedge clk); #1;
        isa_step(w, c, h, t, rd, v, np);
        bus.imem_valid = 1'($urandom);
        bus.imem_rdata = $urandom;
        e_req = 1'b0;
        @(posedge clk); #1;
        if (c) begin
            e_cv = 1'b1; e_cpc = m_pc; e_crd = 32'(rd); e_cdata = v;
        end else begin
            m_halted = 1'b1; e_halt = h; e_trap = t;
        end
        @(posedge clk); #1;
        if (c) begin
            if (rd != 5'd0) m_regs[rd] = v;
            m_pc = np;
        end
        bus.imem_valid = 1'b0;
        set_fetch();
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [19:0] u20;
        logic [7:0]  off;
        logic [20:0] ji;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        i12 = 12'($urandom);
        u20 = 20'($urandom);
        off = 8'($urandom);
        ji  = {{11{off[7]}}, off, 2'b00};
        case ($urandom_range(0, 7))
            0, 1:    rand_insn = {i12, rs1, 3'b000, rd, 7'h13};
            2:       rand_insn = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
            3:       rand_insn = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
            4:       rand_insn = {u20, rd, 7'h37};
            5:       rand_insn = {u20, rd, 7'h17};
            6:       rand_insn = {ji[20], ji[10:1], ji[11], ji[19:12], rd, 7'h6F};
            default: rand_insn = {i12 & 12'hFFC, 5'd0, 3'b000, rd, 7'h67};
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bus.imem_valid   = 1'b0;
        bus.imem_rdata   = 32'd0;
        bus_e.imem_valid = 1'b0;
        bus_e.imem_rdata = 32'd0;

        do_reset();
        run_instr(32'h00A0_0093, 0);
        check("addi_latency", 32'(lc_cyc - cyc0 + 1), 32'd3);
        check("addi_rd", lc_rd, 32'd1);
        check("addi_data", lc_data, 32'd10);
        check("addi_pc", lc_pc, 32'h8000_0000);
        check("addi_next_pc", bus.pc, 32'h8000_0004);

        run_instr(32'hFFF0_0093, 1);
        check("addi_m1", lc_data, 32'hFFFF_FFFF);
        run_instr(32'h0010_8133, 0);
        check("add_wrap", lc_data, 32'hFFFF_FFFE);
        run_instr(32'h0050_8013, 2);
        check("x0_rd", lc_rd, 32'd0);
        run_instr(32'h0000_0233, 0);
        check("x0_read", lc_data, 32'd0);

        idle(1);
        do_reset();
        run_instr(32'h0010_81B3, 0);
        check("regs_cleared", lc_data, 32'd0);

        do_reset();
        run_instr(32'h00A0_0093, 5);
        check("wait5_latency", 32'(lc_cyc - cyc0 + 1), 32'd8);

        for (int n = 0; n < 250; n++) begin
            run_instr(rand_insn(), $urandom_range(0, 2));
        end
        run_instr(32'hFFFF_FFFF, 1);
        idle(4);
        check("illegal_halt", 32'(bus.halt), 32'd1);
        check("illegal_trap", 32'(bus.trap), 32'd1);

        do_reset();
        run_instr(32'h0080_00EF, 0);
        check("jal_link", lc_data, 32'h8000_0004);
        check("jal_target", bus.imem_addr, 32'h8000_0008);
        run_instr(32'h0030_0067, 0);
        idle(3);
        check("jalr_halt", 32'(bus.halt), 32'd1);
        check("jalr_trap", 32'(bus.trap), 32'd1);
        check("jalr_req", 32'(bus.imem_req), 32'd0);

        do_reset();
        run_instr(32'h0010_0073, 0);
        idle(3);
`ifdef NPC_EBREAK_HALT_EN
        check("ebreak_halt", 32'(bus.halt), 32'd1);
        check("ebreak_trap", 32'(bus.trap), 32'd0);
        check("ebreak_req", 32'(bus.imem_req), 32'd0);
`else
        check("ebreak_rd", lc_rd, 32'd0);
        check("ebreak_pc", bus.pc, 32'h8000_0004);
        check("ebreak_halt", 32'(bus.halt), 32'd0);
`endif

        bus_e.imem_valid = 1'b1;
        bus_e.imem_rdata = 32'h0070_0293;
        @(posedge clk); #1;
        bus_e.imem_valid = 1'b0;
        @(posedge clk); #1;
        check("e_commit_valid", 32'(bus_e.commit_valid), 32'd1);
        check("e_commit_rd", 32'(bus_e.commit_rd), 32'd5);
        check("e_commit_data", bus_e.commit_data, 32'd7);
        @(posedge clk); #1;
        bus_e.imem_valid = 1'b1;
        bus_e.imem_rdata = 32'h0010_0813;
        @(posedge clk); #1;
        bus_e.imem_valid = 1'b0;
        @(posedge clk); #1;
        check("e_x16_halt", 32'(bus_e.halt), 32'd1);
        check("e_x16_trap", 32'(bus_e.trap), 32'd1);
        check("e_x16_commit", 32'(bus_e.commit_valid), 32'd0);
        check("e_x16_req", 32'(bus_e.imem_req), 32'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npc_mc.md
# npc_mc

Multi-cycle, parametrised successor to the single-cycle `npc` core. It fetches from an external instruction port using a valid handshake, then decodes, executes and writes back through a four-state FSM. It implements an RV32I/RV32E integer subset with an x0-hardwired register file, jumps, a commit trace port and a halt/trap exit. It sits at the top of the `npc` hierarchy and is driven by the C harness, which supplies instruction memory.

## Interface
Parameters:
- XLEN, 32, datapath width (32 only for RV32; kept as a parameter for 64-bit bring-up)
- NREG, 32, architectural registers; 16 selects RV32E
- RESET_PC, 32'h8000_0000, PC loaded on reset

Ports:
- clk  in  1  core clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- imem_req  out  1  fetch request; held high in FETCH
- imem_addr  out  XLEN  fetch address; equals pc
- imem_valid  in  1  instruction data valid this cycle
- imem_rdata  in  32  instruction word
- pc  out  XLEN  current PC
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  XLEN  PC of the retired instruction
- commit_rd  out  5  destination index; 0 if there is no write
- commit_data  out  XLEN  value written to commit_rd
- halt  out  1  core stopped; sticky until rst
- trap  out  1  halt was caused by an illegal instruction or misaligned target

## Operation
- Supported instructions: LUI, AUIPC, JAL, JALR, ADDI, ADD, SUB, EBREAK. Every other encoding is illegal.
- States:
  - FETCH: imem_req=1 and imem_addr=pc. On imem_valid, latch imem_rdata into the instruction register and go to EXEC. Otherwise stay in FETCH with no timeout.
  - EXEC: decode, read rs1/rs2 and compute result and next_pc, then go to WB. On an illegal instruction go to HALT with trap=1.
  - WB: write rd when rd!=0, pulse commit_valid, set pc<=next_pc, go to FETCH.
  - HALT: imem_req=0. pc is frozen and no commit occurs. Only rst leaves this state.
- Arithmetic:
  - All arithmetic is modulo 2^XLEN with wrap-around and no overflow detection.
  - Immediates are sign-extended to XLEN.
  - LUI produces {imm[31:12], 12'b0}.
- Jumps:
  - JAL and JALR write pc+4 to rd.
  - The JALR target is (rs1+imm) & ~1.
  - If target bit 1 is set, the core goes to HALT with trap=1 and does not write rd.
- Register file:
  - Reads of x0 return 0. Writes to x0 are discarded, and commit_rd still reports 0.
  - With NREG=16, any rs1, rs2 or rd index with bit 4 set is illegal.
  - rs1==rd, for example ADDI x5,x5,1, reads the old value in EXEC and writes in WB. There is no hazard.
- Reset values:
  - pc=RESET_PC, state=FETCH, halt=0, trap=0, commit_valid=0, commit_pc=0, commit_rd=0, commit_data=0.
  - Register contents are 0.
- Reset mid-fetch: an imem_valid arriving in the same cycle as rst is ignored.

## Timing
- Minimum of 3 cycles per instruction, reached when imem_valid is asserted in the first FETCH cycle. Each wait cycle adds 1.
- commit_valid is high for exactly the WB cycle. commit_* fields are valid only while commit_valid is high.
- pc updates on the clock edge that ends WB, so the following FETCH presents the new address.
- halt and trap rise on the edge that ends EXEC and remain high.
- imem_rdata is sampled only in FETCH when imem_valid=1. The harness may hold or change imem_rdata at any other time.

## Configuration
- NPC_EBREAK_HALT_EN defined: EBREAK sends the core to HALT with halt=1, trap=0, and no commit.
- NPC_EBREAK_HALT_EN undefined: EBREAK retires as a NOP, with commit_valid pulsed, commit_rd=0 and pc+4.

## Structure
- Package npc_pkg holds:
  - opcode and funct constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG, OP_SYSTEM)
  - the state typedef (FETCH, EXEC, WB, HALT)
  - the immediate-format enum
- One sub-module, npc_regfile: parameters NREG and XLEN; two combinational read ports and one synchronous write port gated for x0; cleared on rst.
- Decode, ALU and FSM live in npc_mc.

## Test plan
- Reset, then ADDI x1,x0,10 (0x00A00093) with immediate valid:
  - 3 cycles to commit.
  - commit_rd=1, commit_data=10, commit_pc=0x8000_0000.
  - pc then reads 0x8000_0004.
- ADDI x1,x0,-1 then ADD x2,x1,x1:
  - x1=0xFFFF_FFFF, x2=0xFFFF_FFFE (wrap).
  - Then ADDI x0,x1,5 gives commit_rd=0, and x0 still reads 0.
- JAL x1,+8 at 0x8000_0000: commit_data=0x8000_0004 and the next fetch address is 0x8000_0008.
  - JALR x0,3(x0) gives a target of 2, so halt=1 and trap=1.
- imem_valid held low for 5 cycles in FETCH:
  - imem_req stays high and no commit occurs.
  - Retirement happens at cycle 8.
  - Asserting rst in cycle 2 returns pc to RESET_PC.
- EBREAK (0x0010_0073):
  - With NPC_EBREAK_HALT_EN: halt=1, trap=0, imem_req=0 thereafter.
  - Without it: NOP commit and pc+4.
- NREG=16 with ADDI x16,x0,1: halt=1 and trap=1. Word 0xFFFF_FFFF also gives halt=1 and trap=1.
